// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch stage for the 64-bit core.
// Generates sequential fetch PCs and issues in-order requests to instruction
// memory. It buffers the returned 32-bit words with their PCs and presents
// them to decode over a valid/ready handshake.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   redirect_valid/_pc   branch/trap redirect pulse and target (bits [1:0] ignored)
//   imem_req_*           fetch request channel (valid/ready/addr)
//   imem_resp_*          in-order response channel (valid/data/err), never stalled
//   out_*                decode channel (valid/ready/inst/pc/fault)
//   perf_fetched/_dropped  only with IFETCH_PERF_EN defined: pop and discard counters
//
// Optional feature macro: IFETCH_PERF_EN.
module ifetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [63:0] out_pc,
  output logic        out_fault
`ifdef IFETCH_PERF_EN
  ,
  output logic [63:0] perf_fetched,
  output logic [63:0] perf_dropped
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

  state_t          r_state;
  logic            r_req_valid;
  logic [63:0]     r_pc;
  logic [CW-1:0]   r_inflight;
  logic [CW-1:0]   r_drop;
  logic [CW-1:0]   r_count;
  logic [PW-1:0]   r_q_wr, r_q_rd;
  logic [PW-1:0]   r_b_wr, r_b_rd;

  logic [63:0]     r_pcq   [DEPTH];
  logic [31:0]     r_binst [DEPTH];
  logic [63:0]     r_bpc   [DEPTH];
  logic            r_bflt  [DEPTH];

  logic            w_accept, w_discard, w_push, w_pop, w_nonempty, w_credit_ok;
  logic [CW-1:0]   w_inflight_nxt, w_count_nxt, w_drop_nxt;
  logic [63:0]     w_pc_nxt;
  state_t          w_state_nxt;
  logic            w_req_valid_nxt;
  logic            w_unused_rpc_lo;

  assign w_unused_rpc_lo = ^redirect_pc[1:0];

  assign w_accept   = r_req_valid & imem_req_ready;
  // Responses of a stale stream (pending drop, halted, or arriving while the
  // redirect is flushing) never enter the buffer.
  assign w_discard  = imem_resp_valid &
                      ((r_drop != '0) | (r_state == ST_HALT) | redirect_valid);
  assign w_push     = imem_resp_valid & ~w_discard;
  assign w_nonempty = (r_count != '0);
  assign w_pop      = out_valid & out_ready;

  assign w_inflight_nxt = r_inflight + CW'(w_accept) - CW'(imem_resp_valid);
  assign w_count_nxt    = redirect_valid ? '0 : (r_count + CW'(w_push) - CW'(w_pop));
  assign w_credit_ok    = ({1'b0, w_inflight_nxt} + {1'b0, w_count_nxt}) < DEPTH_C;

  always_comb begin
    w_state_nxt = r_state;
    if (redirect_valid)
      w_state_nxt = ST_RUN;
    else if (r_state == ST_RUN && w_push && imem_resp_err)
      w_state_nxt = ST_HALT;

    // Everything still outstanding after a redirect belongs to the old stream.
    w_drop_nxt = r_drop;
    if (redirect_valid)
      w_drop_nxt = w_inflight_nxt;
    else if (imem_resp_valid && r_drop != '0)
      w_drop_nxt = r_drop - 1'b1;

    w_pc_nxt = r_pc;
    if (redirect_valid)
      w_pc_nxt = {redirect_pc[63:2], 2'b00};
    else if (w_accept)
      w_pc_nxt = r_pc + 64'd4;

    // An unaccepted request is held stable; only a redirect may withdraw it.
    w_req_valid_nxt = 1'b0;
    if (redirect_valid)
      w_req_valid_nxt = w_credit_ok;
    else if (r_req_valid && !w_accept)
      w_req_valid_nxt = 1'b1;
    else
      w_req_valid_nxt = (w_state_nxt == ST_RUN) && w_credit_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_req_valid <= 1'b0;
      r_pc        <= RESET_PC;
      r_inflight  <= '0;
      r_drop      <= '0;
      r_count     <= '0;
      r_q_wr      <= '0;
      r_q_rd      <= '0;
      r_b_wr      <= '0;
      r_b_rd      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_req_valid <= w_req_valid_nxt;
      r_pc        <= w_pc_nxt;
      r_inflight  <= w_inflight_nxt;
      r_drop      <= w_drop_nxt;
      r_count     <= w_count_nxt;
      // The PC queue tracks every outstanding request, dropped ones included,
      // so it is never flushed.
      if (w_accept)        r_q_wr <= r_q_wr + 1'b1;
      if (imem_resp_valid) r_q_rd <= r_q_rd + 1'b1;
      if (redirect_valid) begin
        r_b_wr <= '0;
        r_b_rd <= '0;
      end else begin
        if (w_push) r_b_wr <= r_b_wr + 1'b1;
        if (w_pop)  r_b_rd <= r_b_rd + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept)
      r_pcq[r_q_wr] <= r_pc;
    if (w_push) begin
      r_binst[r_b_wr] <= imem_resp_err ? 32'h0 : imem_resp_data;
      r_bpc[r_b_wr]   <= r_pcq[r_q_rd];
      r_bflt[r_b_wr]  <= imem_resp_err;
    end
  end

  assign imem_req_valid = r_req_valid;
  assign imem_req_addr  = r_pc;
  assign out_valid      = w_nonempty & ~redirect_valid;
  assign out_inst       = w_nonempty ? r_binst[r_b_rd] : 32'h0;
  assign out_pc         = w_nonempty ? r_bpc[r_b_rd]   : 64'h0;
  assign out_fault      = w_nonempty ? r_bflt[r_b_rd]  : 1'b0;

`ifdef IFETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_dropped <= '0;
    end else begin
      if (w_pop)     perf_fetched <= perf_fetched + 64'd1;
      if (w_discard) perf_dropped <= perf_dropped + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [63:0] out_pc;
  logic        out_fault;
`ifdef IFETCH_PERF_EN
  logic [63:0] perf_fetched;
  logic [63:0] perf_dropped;
`endif

  always #5 clk = ~clk;

  ifetch_unit #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .imem_resp_err   (imem_resp_err),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_inst        (out_inst),
    .out_pc          (out_pc),
    .out_fault       (out_fault)
`ifdef IFETCH_PERF_EN
    ,
    .perf_fetched    (perf_fetched),
    .perf_dropped    (perf_dropped)
`endif
  );

  // Memory-side record of an accepted request and decode-side expected entry.
  typedef struct { logic [63:0] addr; int epoch; int acc_cyc; } mreq_t;
  typedef struct { logic [63:0] pc; logic [31:0] inst; logic flt; } exp_t;
  typedef struct {
    int ncyc; bit ordy; bit mrdy; bit ren; bit redir; logic [63:0] rpc; logic [63:0] eaddr;
    bit chk_first; logic [63:0] first;
    bit chk_end; bit end_req_v; bit end_out_v; bit chk_end_pc; logic [63:0] end_pc;
  } phase_t;

  mreq_t mq[$];
  exp_t  exp_q[$];
  phase_t tbl[10];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int epoch = 0;
  int n_pops = 0;
  int n_disc = 0;
  int n_req_halted = 0;
  bit halted = 0;
  bit mem_rdy = 0;
  bit resp_en = 1;
  bit chk_stall = 0;
  bit got_first = 0;
  logic [63:0] first_pc = '1;
  logic [63:0] exp_req_addr = RESET_PC;
  logic [63:0] err_addr = 64'h1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mdata(input logic [63:0] a);
    return ~a[31:0] ^ a[63:32] ^ 32'h1357_9bdf;
  endfunction

  function automatic phase_t ph(input int n, input bit o, input bit m, input bit r,
                                input bit rd, input logic [63:0] rpc, input logic [63:0] ea,
                                input bit cf, input logic [63:0] f, input bit ce,
                                input bit erv, input bit eov, input bit cep,
                                input logic [63:0] ep);
    phase_t p;
    p.ncyc = n; p.ordy = o; p.mrdy = m; p.ren = r; p.redir = rd; p.rpc = rpc; p.eaddr = ea;
    p.chk_first = cf; p.first = f; p.chk_end = ce; p.end_req_v = erv; p.end_out_v = eov;
    p.chk_end_pc = cep; p.end_pc = ep;
    return p;
  endfunction

  task automatic step(input bit redir, input logic [63:0] rpc, input bit ordy);
    mreq_t m;
    exp_t  e;
    exp_t  pend;
    bit    have_resp;
    bit    do_push;
    @(negedge clk);
    redirect_valid = redir;
    redirect_pc    = rpc;
    out_ready      = ordy;
    imem_req_ready = mem_rdy;
    have_resp = resp_en && (mq.size() > 0) && (mq[0].acc_cyc < cyc);
    if (have_resp) begin
      m = mq.pop_front();
      imem_resp_valid = 1'b1;
      imem_resp_data  = mdata(m.addr);
      imem_resp_err   = (m.addr == err_addr);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
      imem_resp_err   = 1'b0;
    end
    #1;
    if (halted && imem_req_valid) n_req_halted++;
    if (chk_stall) begin
      chk("stall_req_valid", 64'(imem_req_valid), 64'd1);
      chk("stall_req_addr", imem_req_addr, RESET_PC);
    end
    chk("out_valid", 64'(out_valid), 64'((exp_q.size() != 0) && !redir));
    if (out_valid && out_ready && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pop_pc", out_pc, e.pc);
      chk("pop_inst", 64'(out_inst), 64'(e.inst));
      chk("pop_fault", 64'(out_fault), 64'(e.flt));
      n_pops++;
      if (!got_first) begin
        got_first = 1;
        first_pc  = out_pc;
      end
    end
    if (imem_req_valid && imem_req_ready) begin
      chk("req_addr", imem_req_addr, exp_req_addr);
      mq.push_back('{imem_req_addr, epoch, cyc});
      exp_req_addr = exp_req_addr + 64'd4;
    end
    if (redir) begin
      epoch++;
      exp_q.delete();
      halted = 0;
      exp_req_addr = {rpc[63:2], 2'b00};
    end
    do_push = 0;
    if (have_resp) begin
      if (m.epoch == epoch && !halted) begin
        do_push   = 1;
        pend.pc   = m.addr;
        pend.flt  = (m.addr == err_addr);
        pend.inst = pend.flt ? 32'h0 : mdata(m.addr);
        if (pend.flt) halted = 1;
      end else begin
        n_disc++;
      end
    end
    @(posedge clk);
    cyc++;
    if (do_push) exp_q.push_back(pend);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //             n  ordy mrdy ren redir rpc                     err_addr              chkF first                   chkE reqV outV chkPC end_pc
    tbl[0] = ph(10, 0, 1, 1, 0, 64'h0,                 64'h1,                0, 64'h0,                 1, 0, 1, 1, 64'h8000_0000);
    tbl[1] = ph(12, 1, 1, 1, 0, 64'h0,                 64'h1,                1, 64'h8000_0000,         0, 0, 0, 0, 64'h0);
    tbl[2] = ph( 6, 1, 1, 0, 0, 64'h0,                 64'h1,                0, 64'h0,                 1, 0, 0, 0, 64'h0);
    tbl[3] = ph(12, 1, 1, 1, 1, 64'h1002,              64'h1,                1, 64'h1000,              0, 0, 0, 0, 64'h0);
    tbl[4] = ph(12, 1, 1, 1, 1, 64'h8000_0000,         64'h8000_0004,        1, 64'h8000_0000,         1, 0, 0, 0, 64'h0);
    tbl[5] = ph( 8, 1, 1, 1, 1, 64'h2000,              64'h1,                1, 64'h2000,              0, 0, 0, 0, 64'h0);
    tbl[6] = ph( 8, 0, 1, 1, 0, 64'h0,                 64'h1,                0, 64'h0,                 1, 0, 1, 0, 64'h0);
    tbl[7] = ph( 6, 0, 1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h1,              0, 64'h0,                 1, 0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC);
    tbl[8] = ph( 6, 1, 1, 1, 0, 64'h0,                 64'h1,                1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0, 0, 64'h0);
    tbl[9] = ph( 4, 1, 1, 0, 0, 64'h0,                 64'h1,                0, 64'h0,                 1, 0, 0, 0, 64'h0);

    rst_n = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    out_ready = 1'b0;
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data = '0;
    imem_resp_err = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rst_req_addr", imem_req_addr, RESET_PC);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_inst", 64'(out_inst), 64'd0);
    chk("rst_out_pc", out_pc, 64'd0);
    chk("rst_out_fault", 64'(out_fault), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Memory not ready: the first request must be held stable.
    mem_rdy = 0;
    chk_stall = 1;
    repeat (5) step(1'b0, 64'h0, 1'b1);
    chk_stall = 0;

    for (int i = 0; i < 10; i++) begin
      mem_rdy = tbl[i].mrdy;
      resp_en = tbl[i].ren;
      err_addr = tbl[i].eaddr;
      got_first = 0;
      first_pc = '1;
      n_req_halted = 0;
      for (int c = 0; c < tbl[i].ncyc; c++)
        step(tbl[i].redir && (c == 0), tbl[i].rpc, tbl[i].ordy);
      #1;
      if (tbl[i].chk_first) chk($sformatf("first_pc[%0d]", i), first_pc, tbl[i].first);
      if (tbl[i].chk_end) begin
        chk($sformatf("end_req_valid[%0d]", i), 64'(imem_req_valid), 64'(tbl[i].end_req_v));
        chk($sformatf("end_out_valid[%0d]", i), 64'(out_valid), 64'(tbl[i].end_out_v));
      end
      if (tbl[i].chk_end_pc) chk($sformatf("end_out_pc[%0d]", i), out_pc, tbl[i].end_pc);
      chk($sformatf("req_while_halted[%0d]", i), 64'(n_req_halted), 64'd0);
    end

    // Back-to-back redirects with two requests still in flight: the last wins.
    mem_rdy = 1;
    resp_en = 1;
    got_first = 0;
    first_pc = '1;
    step(1'b1, 64'h3000, 1'b1);
    step(1'b1, 64'h4000, 1'b1);
    repeat (10) step(1'b0, 64'h0, 1'b1);
    #1;
    chk("b2b_first_pc", first_pc, 64'h4000);

`ifdef IFETCH_PERF_EN
    chk("perf_fetched", perf_fetched, 64'(n_pops));
    chk("perf_dropped", perf_dropped, 64'(n_disc));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
